// File: rtl/param_counter_if.sv
// Bus bundle for param_counter: control inputs and count/flag/display outputs.
// The counter is the slave side; the driving environment is the master side.
interface param_counter_if #(
    parameter int WIDTH = 4
);
    logic             iEn;
    logic             iUp;
    logic             iLoad;
    logic [WIDTH-1:0] iLoadVal;
    logic [WIDTH-1:0] oQ;
    logic             oTick;
    logic             oTc;
    logic [6:0]       oDisplay;

    modport master (
        output iEn, iUp, iLoad, iLoadVal,
        input  oQ, oTick, oTc, oDisplay
    );

    modport slave (
        input  iEn, iUp, iLoad, iLoadVal,
        output oQ, oTick, oTc, oDisplay
    );
endinterface

// File: rtl/param_counter.sv
// Modulo-N up/down counter with load, power-of-two prescaler and optional
// seven-segment output (active-low, {g,f,e,d,c,b,a}).
// Build option: define PARAM_COUNTER_DISPLAY_EN to build the hex decoder;
// without it oDisplay is held at all segments off.
module param_counter #(
    parameter int MODULUS  = 8,
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 25
) (
    input logic           CLK,
    input logic           rst_n,
    param_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] load_val;

    if (PRESCALE > 0) begin : g_pre
        logic [PRESCALE-1:0] pre_q, pre_d;

        assign pre_d = pre_q + PRESCALE'(1);
        assign tick  = &pre_q;

        // Free-running prescaler; wraps naturally at all ones.
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) pre_q <= '0;
            else        pre_q <= pre_d;
        end
    end else begin : g_nopre
        assign tick = 1'b1;
    end

    // Out-of-range load values saturate to the top of the sequence.
    assign load_val = (32'(bus.iLoadVal) >= MODULUS) ? MAX : bus.iLoadVal;

    // Next count: load beats a counting step, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (bus.iLoad) begin
            q_d = load_val;
        end else if (tick && bus.iEn) begin
            if (bus.iUp) q_d = (q_q == MAX) ? '0 : q_q + WIDTH'(1);
            else         q_d = (q_q == '0) ? MAX : q_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign bus.oQ    = q_q;
    assign bus.oTick = tick;
    assign bus.oTc   = bus.iEn & ((bus.iUp & (q_q == MAX)) | (~bus.iUp & (q_q == '0)));

`ifdef PARAM_COUNTER_DISPLAY_EN
    logic [3:0] nib;
    logic [6:0] seg;

    if (WIDTH >= 4) begin : g_nib_trunc
        assign nib = q_q[3:0];
    end else begin : g_nib_ext
        assign nib = {{(4 - WIDTH){1'b0}}, q_q};
    end

    // Hex to active-low segment decode.
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

    assign bus.oDisplay = seg;
`else
    assign bus.oDisplay = 7'b1111111;
`endif
endmodule
